// File: rtl/rename_pkg.sv
// Shared rename-stage sizing and tag/pointer/page types.
package rename_pkg;

  localparam int unsigned NUM_PHYS  = 256;
  localparam int unsigned NUM_ARCH  = 32;
  localparam int unsigned NUM_PAGES = 8;
  localparam int unsigned TAG_W     = $clog2(NUM_PHYS);
  localparam int unsigned PAGE_W    = $clog2(NUM_PAGES);

  typedef logic [TAG_W-1:0]  phys_tag_t;
  typedef logic [TAG_W:0]    fl_ptr_t;
  typedef logic [PAGE_W-1:0] page_t;

  localparam fl_ptr_t RESET_TAIL = fl_ptr_t'(NUM_PHYS - NUM_ARCH);
  localparam fl_ptr_t FULL_COUNT = fl_ptr_t'(NUM_PHYS);

endpackage

// File: rtl/fl_ckpt_file.sv
// Branch checkpoint storage for the free-list head pointer, one valid bit per page.
module fl_ckpt_file
  import rename_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    save_en,
  input  page_t   save_page,
  input  fl_ptr_t save_ptr,
  input  logic    clear_en,
  input  page_t   rd_page,
  output fl_ptr_t rd_ptr,
  output logic    rd_valid
);

  fl_ptr_t               ckpt_q [NUM_PAGES];
  logic [NUM_PAGES-1:0]  valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < NUM_PAGES; i++) ckpt_q[i] <= '0;
    end else begin
      if (save_en) begin
        ckpt_q[save_page]  <= save_ptr;
        valid_q[save_page] <= 1'b1;
      end
      if (clear_en) valid_q[rd_page] <= 1'b0;
    end
  end

  assign rd_ptr   = ckpt_q[rd_page];
  assign rd_valid = valid_q[rd_page];

endmodule

// File: rtl/phys_free_list.sv
// Circular FIFO of free physical tags: rename pops at head, commit pushes at tail,
// branch checkpoints snapshot and restore the head pointer.
module phys_free_list
  import rename_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             release_valid,
  input  logic [TAG_W-1:0] release_tag,
  input  logic             save_state,
  input  logic [PAGE_W-1:0] save_page,
  input  logic             restore_state,
  input  logic [PAGE_W-1:0] restore_page,
  output logic [TAG_W:0]   free_count,
  output logic             fl_err
);

  phys_tag_t mem [NUM_PHYS];
  fl_ptr_t   head_q, tail_q, head_next, tail_next, free_count_q;
  fl_ptr_t   ckpt_ptr;
  logic      ckpt_valid;
  logic      do_pop, do_push, do_restore, do_save, tag_nonzero, is_full, err_next;

  assign alloc_ready = (free_count_q != '0);
  assign alloc_tag   = mem[head_q[TAG_W-1:0]];
  assign free_count  = free_count_q;

  always_comb begin
    tag_nonzero = release_valid && (release_tag != '0);
    is_full     = (free_count_q == FULL_COUNT);
    do_pop      = alloc_req && alloc_ready && !restore_state;
    do_push     = tag_nonzero && !is_full;
    do_restore  = restore_state && ckpt_valid;
    do_save     = save_state && !restore_state;
    err_next    = (alloc_req && !alloc_ready) || (tag_nonzero && is_full) ||
                  (restore_state && !ckpt_valid);
    head_next   = do_restore ? ckpt_ptr : head_q + fl_ptr_t'(do_pop);
    tail_next   = tail_q + fl_ptr_t'(do_push);
  end

  // Checkpoint captures the post-pop head so the saving instruction keeps its own tag.
  fl_ckpt_file u_ckpt (
    .clk       (clk),
    .rst       (rst),
    .save_en   (do_save),
    .save_page (save_page),
    .save_ptr  (head_q + fl_ptr_t'(do_pop)),
    .clear_en  (do_restore),
    .rd_page   (restore_page),
    .rd_ptr    (ckpt_ptr),
    .rd_valid  (ckpt_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= RESET_TAIL;
      free_count_q <= RESET_TAIL;
      fl_err       <= 1'b0;
    end else begin
      head_q       <= head_next;
      tail_q       <= tail_next;
      free_count_q <= tail_next - head_next;
      fl_err       <= err_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PHYS; i++)
        mem[i] <= (i < NUM_PHYS - NUM_ARCH) ? phys_tag_t'(NUM_ARCH + i) : '0;
    end else if (do_push) begin
      mem[tail_q[TAG_W-1:0]] <= release_tag;
    end
  end

endmodule

// File: tb/tb_phys_free_list.sv
// Scoreboard bench for phys_free_list: queue model of free tags plus an allocation log for rollback.
module tb_phys_free_list;
  import rename_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            alloc_req, alloc_ready, release_valid, save_state, restore_state, fl_err;
  phys_tag_t       alloc_tag, release_tag;
  page_t           save_page, restore_page;
  logic [TAG_W:0]  free_count;

  always #5 clk = ~clk;

  phys_free_list dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .release_valid(release_valid), .release_tag(release_tag),
    .save_state(save_state), .save_page(save_page),
    .restore_state(restore_state), .restore_page(restore_page),
    .free_count(free_count), .fl_err(fl_err)
  );

  int        n_checks = 0;
  int        n_fail   = 0;
  phys_tag_t exp_q[$];
  phys_tag_t alloc_log[$];
  int        ckpt_cnt [NUM_PAGES];
  bit        ckpt_vld [NUM_PAGES];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req = 0; release_valid = 0; release_tag = '0;
    save_state = 0; save_page = '0; restore_state = 0; restore_page = '0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    alloc_log.delete();
    for (int i = 0; i < int'(NUM_PHYS - NUM_ARCH); i++) exp_q.push_back(phys_tag_t'(int'(NUM_ARCH) + i));
    for (int p = 0; p < int'(NUM_PAGES); p++) begin ckpt_vld[p] = 0; ckpt_cnt[p] = 0; end
  endtask

  // Drive one cycle of stimulus and advance the scoreboard model the same way.
  task automatic cycle(input bit a, input bit rv, input phys_tag_t rt,
                       input bit sv, input page_t sp, input bit rs, input page_t rp,
                       output bit e);
    bit ready, rest_ok, pop, push;
    int cnt;
    alloc_req = a; release_valid = rv; release_tag = rt;
    save_state = sv; save_page = sp; restore_state = rs; restore_page = rp;
    e       = 0;
    ready   = exp_q.size() != 0;
    rest_ok = rs && ckpt_vld[rp];
    if (rs && !ckpt_vld[rp]) e = 1;
    if (a && !ready) e = 1;
    pop  = a && ready && !rs;
    push = 0;
    if (rv && rt != 0) begin
      if (exp_q.size() == int'(NUM_PHYS)) e = 1;
      else push = 1;
    end
    if (pop) alloc_log.push_back(exp_q.pop_front());
    if (sv && !rs) begin ckpt_cnt[sp] = alloc_log.size(); ckpt_vld[sp] = 1; end
    if (rest_ok) begin
      cnt = ckpt_cnt[rp];
      for (int k = alloc_log.size() - 1; k >= cnt; k--) exp_q.push_front(alloc_log[k]);
      while (alloc_log.size() > cnt) void'(alloc_log.pop_back());
      ckpt_vld[rp] = 0;
    end
    if (push) exp_q.push_back(rt);
    step();
    idle();
  endtask

  task automatic test_reset();
    n_checks++; if (alloc_tag !== 8'd32) begin n_fail++; $display("FAIL reset_tag: got %0d want 32", alloc_tag); end
    n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", alloc_ready); end
    n_checks++; if (free_count !== 9'd224) begin n_fail++; $display("FAIL reset_count: got %0d want 224", free_count); end
    n_checks++; if (fl_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", fl_err); end
  endtask

  task automatic test_drain();
    bit e;
    for (int i = 0; i < 224; i++) begin
      n_checks++;
      if (alloc_tag !== exp_q[0] || alloc_tag !== phys_tag_t'(32 + i)) begin
        n_fail++; $display("FAIL drain_tag[%0d]: got %0d want %0d", i, alloc_tag, 32 + i);
      end
      cycle(1, 0, '0, 0, '0, 0, '0, e);
    end
    n_checks++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL empty_ready: got %b want 0", alloc_ready); end
    n_checks++; if (free_count !== 9'd0) begin n_fail++; $display("FAIL empty_count: got %0d want 0", free_count); end
    cycle(1, 0, '0, 0, '0, 0, '0, e);
    n_checks++; if (fl_err !== e || e !== 1'b1) begin n_fail++; $display("FAIL underflow_err: got %b want 1", fl_err); end
    n_checks++; if (free_count !== 9'd0) begin n_fail++; $display("FAIL underflow_count: got %0d want 0", free_count); end
    cycle(0, 0, '0, 0, '0, 0, '0, e);
    n_checks++; if (fl_err !== 1'b0) begin n_fail++; $display("FAIL underflow_pulse: got %b want 0", fl_err); end
  endtask

  task automatic test_refill();
    bit e;
    cycle(0, 1, 8'd40, 0, '0, 0, '0, e);
    n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL refill_ready: got %b want 1", alloc_ready); end
    n_checks++; if (alloc_tag !== 8'd40) begin n_fail++; $display("FAIL refill_head: got %0d want 40", alloc_tag); end
    cycle(0, 1, 8'd41, 0, '0, 0, '0, e);
    cycle(0, 1, 8'd42, 0, '0, 0, '0, e);
    n_checks++; if (free_count !== 9'd3) begin n_fail++; $display("FAIL refill_count: got %0d want 3", free_count); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (alloc_tag !== exp_q[0]) begin n_fail++; $display("FAIL refill_order[%0d]: got %0d want %0d", i, alloc_tag, exp_q[0]); end
      cycle(1, 0, '0, 0, '0, 0, '0, e);
    end
  endtask

  task automatic test_checkpoint();
    bit e;
    logic [TAG_W:0] fc_before;
    for (int t = 43; t <= 52; t++) cycle(0, 1, phys_tag_t'(t), 0, '0, 0, '0, e);
    cycle(1, 0, '0, 0, '0, 0, '0, e);
    cycle(1, 0, '0, 0, '0, 0, '0, e);
    n_checks++; if (alloc_tag !== 8'd45) begin n_fail++; $display("FAIL ckpt_head: got %0d want 45", alloc_tag); end
    cycle(0, 0, '0, 1, 3'd3, 0, '0, e);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (alloc_tag !== exp_q[0]) begin n_fail++; $display("FAIL ckpt_alloc[%0d]: got %0d want %0d", i, alloc_tag, exp_q[0]); end
      cycle(1, 0, '0, 0, '0, 0, '0, e);
    end
    fc_before = free_count;
    cycle(0, 0, '0, 0, '0, 1, 3'd3, e);
    n_checks++; if (alloc_tag !== 8'd45) begin n_fail++; $display("FAIL restore_head: got %0d want 45", alloc_tag); end
    n_checks++; if (free_count !== fc_before + 9'd4) begin n_fail++; $display("FAIL restore_count: got %0d want %0d", free_count, fc_before + 9'd4); end
    n_checks++; if (fl_err !== 1'b0) begin n_fail++; $display("FAIL restore_err: got %b want 0", fl_err); end
    cycle(0, 0, '0, 0, '0, 1, 3'd3, e);
    n_checks++; if (fl_err !== e || e !== 1'b1) begin n_fail++; $display("FAIL restore_invalid_err: got %b want 1", fl_err); end
    n_checks++; if (alloc_tag !== 8'd45 || free_count !== fc_before + 9'd4) begin
      n_fail++; $display("FAIL restore_invalid_state: got tag %0d count %0d want 45 %0d", alloc_tag, free_count, fc_before + 9'd4);
    end
  endtask

  task automatic test_collisions();
    bit e;
    logic [TAG_W:0] fc_before;
    cycle(0, 0, '0, 1, 3'd5, 0, '0, e);
    cycle(1, 0, '0, 0, '0, 0, '0, e);
    cycle(1, 0, '0, 0, '0, 0, '0, e);
    fc_before = free_count;
    cycle(1, 1, 8'd77, 0, '0, 1, 3'd5, e);
    n_checks++; if (alloc_tag !== 8'd45) begin n_fail++; $display("FAIL collide_head: got %0d want 45", alloc_tag); end
    n_checks++; if (free_count !== fc_before + 9'd3) begin n_fail++; $display("FAIL collide_count: got %0d want %0d", free_count, fc_before + 9'd3); end
    cycle(0, 0, '0, 1, 3'd2, 0, '0, e);
    cycle(1, 0, '0, 0, '0, 0, '0, e);
    cycle(0, 0, '0, 1, 3'd6, 1, 3'd2, e);
    n_checks++; if (alloc_tag !== exp_q[0] || fl_err !== 1'b0) begin
      n_fail++; $display("FAIL save_restore_head: got %0d err %b want %0d err 0", alloc_tag, fl_err, exp_q[0]);
    end
    cycle(0, 0, '0, 0, '0, 1, 3'd6, e);
    n_checks++; if (fl_err !== e || e !== 1'b1) begin n_fail++; $display("FAIL save_discarded: got %b want 1", fl_err); end
    while (exp_q.size() > 0) begin
      n_checks++;
      if (alloc_tag !== exp_q[0]) begin n_fail++; $display("FAIL collide_drain: got %0d want %0d", alloc_tag, exp_q[0]); end
      cycle(1, 0, '0, 0, '0, 0, '0, e);
    end
    n_checks++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL collide_empty: got %b want 0", alloc_ready); end
  endtask

  task automatic test_full();
    bit e;
    rst = 1; step(); rst = 0; model_reset(); step();
    for (int t = 1; t <= 32; t++) cycle(0, 1, phys_tag_t'(t), 0, '0, 0, '0, e);
    n_checks++; if (free_count !== 9'd256) begin n_fail++; $display("FAIL full_count: got %0d want 256", free_count); end
    cycle(0, 1, 8'd99, 0, '0, 0, '0, e);
    n_checks++; if (fl_err !== e || e !== 1'b1) begin n_fail++; $display("FAIL overflow_err: got %b want 1", fl_err); end
    n_checks++; if (free_count !== 9'd256) begin n_fail++; $display("FAIL overflow_count: got %0d want 256", free_count); end
  endtask

  task automatic test_zero_and_async_reset();
    bit e;
    logic [TAG_W:0] fc_before;
    fc_before = free_count;
    cycle(1, 1, 8'd0, 0, '0, 0, '0, e);
    n_checks++; if (free_count !== fc_before - 9'd1 || fl_err !== 1'b0) begin
      n_fail++; $display("FAIL release_zero: got count %0d err %b want %0d 0", free_count, fl_err, fc_before - 9'd1);
    end
    alloc_req = 1;
    step(); step(); step();
    #2 rst = 1;
    #1;
    n_checks++; if (alloc_tag !== 8'd32 || free_count !== 9'd224 || alloc_ready !== 1'b1 || fl_err !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got tag %0d count %0d ready %b err %b want 32 224 1 0", alloc_tag, free_count, alloc_ready, fl_err);
    end
    idle();
    step(); rst = 0; model_reset();
    n_checks++; if (alloc_tag !== exp_q[0] || free_count !== 9'd224) begin
      n_fail++; $display("FAIL post_reset: got tag %0d count %0d want 32 224", alloc_tag, free_count);
    end
  endtask

  initial begin
    rst = 1;
    idle();
    model_reset();
    step(); step();
    rst = 0;
    test_reset();
    test_drain();
    test_refill();
    test_checkpoint();
    test_collisions();
    test_full();
    test_zero_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
